// File: rtl/seq_detect_pkg.sv
// -----------------------------------------------------------------------------
// seq_detect_pkg
// Shared definitions for the parametrised serial pattern detector:
//   - state_t       : detector FSM encoding (IDLE / FILL / RUN)
//   - DEF_LEN       : pattern length loaded at reset
//   - DEF_OVERLAP   : overlap mode loaded at reset
// With the reset pattern of all ones, DEF_LEN=2 and DEF_OVERLAP=1 the block
// behaves exactly like the legacy "11" detector.
// -----------------------------------------------------------------------------
package seq_detect_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam int   DEF_LEN     = 2;
  localparam logic DEF_OVERLAP = 1'b1;

endpackage : seq_detect_pkg

// File: rtl/seq_detect_param_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter with synchronous clear.
// Ports:
//   clk   in  1  clock, rising edge
//   reset in  1  synchronous, active-high reset (count -> 0)
//   inc   in  1  increment request; ignored once the count is all ones
//   clr   in  1  synchronous clear; wins over inc
//   cnt   out W  current count
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt = r_cnt;

endmodule : sat_counter

// File: rtl/seq_detect_param.sv
// -----------------------------------------------------------------------------
// seq_detect_param
// Run-time programmable serial pattern detector (length 1..PAT_W) with an
// input-valid qualifier, overlap / non-overlap mode, a registered one-cycle
// match pulse and a saturating match counter.
//
// Ports:
//   clk        in  1      clock, rising edge
//   reset      in  1      synchronous, active-high reset
//   enable     in  1      1 = detector running, 0 = idle with history flushed
//   din        in  1      serial data bit
//   din_valid  in  1      din is sampled only when 1
//   cfg_load   in  1      capture pattern_i/len_i/overlap_i (only when enable=0)
//   pattern_i  in  PAT_W  pattern; [len-1] is received first, [0] last
//   len_i      in  LEN_W  pattern length; 0 or >PAT_W clamps to PAT_W
//   overlap_i  in  1      1 = overlapping matches, 0 = restart after a match
//   cnt_clr    in  1      synchronous clear of match_cnt (wins over a match)
//   match      out 1      registered one-cycle match pulse (1 clk latency)
//   match_cnt  out CNT_W  saturating match count
//   busy       out 1      1 whenever the FSM is not IDLE
//   dbg_state  out 2      raw FSM state for observation
//
// Handshake: a bit is consumed on a rising edge exactly when din_valid=1 and
// the FSM is in FILL or RUN with enable=1; there is no back-pressure, so the
// source must not rely on any ready indication.
// -----------------------------------------------------------------------------
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             din,
  input  logic             din_valid,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] pattern_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             overlap_i,
  input  logic             cnt_clr,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  localparam logic [LEN_W-1:0] L_PAT_W   = LEN_W'(PAT_W);
  localparam logic [LEN_W-1:0] L_DEF_LEN = LEN_W'(DEF_LEN);

  // Configuration registers
  logic [PAT_W-1:0] r_pat;
  logic [LEN_W-1:0] r_len;
  logic             r_ovl;

  // Detector state. The window never reaches past hist[PAT_W-2] because the
  // newest bit comes straight from din, so only PAT_W-1 history bits are kept.
  state_t           r_state;
  logic [PAT_W-2:0] r_hist;
  logic [LEN_W-1:0] r_fill;
  logic             r_match;

  logic [PAT_W-1:0] w_hist_next;
  logic [PAT_W-1:0] w_mask;
  logic [LEN_W-1:0] w_len_m1;
  logic [LEN_W-1:0] w_fill_inc;
  logic [LEN_W-1:0] w_len_clamped;
  logic             w_fill_ok;
  logic             w_sample;
  logic             w_match;

  // Post-shift history: the window is its low len bits.
  assign w_hist_next = {r_hist, din};
  assign w_len_m1    = r_len - 1'b1;
  assign w_fill_ok   = (r_fill >= w_len_m1);
  // fill_cnt saturates at len so it cannot wrap on long streams.
  assign w_fill_inc  = (r_fill >= r_len) ? r_len : (r_fill + 1'b1);

  assign w_len_clamped = ((len_i == '0) || (len_i > L_PAT_W)) ? L_PAT_W : len_i;

  // Mask selecting the low len bits of the window.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      w_mask[i] = (i < int'(r_len));
    end
  end

  assign w_sample = (r_state != IDLE) && enable && din_valid;
  assign w_match  = w_sample && w_fill_ok &&
                    (((w_hist_next ^ r_pat) & w_mask) == '0);

  // Configuration capture; a load while running is ignored so the pattern
  // never changes under a partially filled window.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pat <= '1;
      r_len <= L_DEF_LEN;
      r_ovl <= DEF_OVERLAP;
    end else if (cfg_load && !enable) begin
      r_pat <= pattern_i;
      r_len <= w_len_clamped;
      r_ovl <= overlap_i;
    end
  end

  // Detector FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_hist  <= '0;
      r_fill  <= '0;
      r_match <= 1'b0;
    end else begin
      r_match <= 1'b0;
      case (r_state)
        IDLE: begin
          r_hist <= '0;
          r_fill <= '0;
          if (enable) begin
            r_state <= FILL;
          end
        end
        FILL, RUN: begin
          if (!enable) begin
            r_state <= IDLE;
            r_hist  <= '0;
            r_fill  <= '0;
          end else if (din_valid) begin
            r_match <= w_match;
            if (w_match && !r_ovl) begin
              // Non-overlap: the next match needs len fresh bits.
              r_hist  <= '0;
              r_fill  <= '0;
              r_state <= FILL;
            end else begin
              r_hist  <= w_hist_next[PAT_W-2:0];
              r_fill  <= w_fill_inc;
              r_state <= (w_fill_inc >= w_len_m1) ? RUN : FILL;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_hist  <= '0;
          r_fill  <= '0;
        end
      endcase
    end
  end

  // Counter advances on the same edge that raises the match pulse.
  sat_counter #(
    .W(CNT_W)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_match),
    .clr   (cnt_clr),
    .cnt   (match_cnt)
  );

  assign match     = r_match;
  assign busy      = (r_state != IDLE);
  assign dbg_state = r_state;

endmodule : seq_detect_param

// File: tb/tb_seq_detect_param.sv
// -----------------------------------------------------------------------------
// tb_seq_detect_param
// Two detector instances (8-bit and 2-bit match counter) share one stimulus
// stream. A reference model keeps the list of bits received since the last
// flush and compares its tail against the pattern after every clock.
// -----------------------------------------------------------------------------
module tb_seq_detect_param;

  localparam int PAT_W = 8;
  localparam int LEN_W = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset     = 1'b1;
  logic             enable    = 1'b0;
  logic             din       = 1'b0;
  logic             din_valid = 1'b0;
  logic             cfg_load  = 1'b0;
  logic [PAT_W-1:0] pattern_i = '0;
  logic [LEN_W-1:0] len_i     = '0;
  logic             overlap_i = 1'b0;
  logic             cnt_clr   = 1'b0;

  logic       match8, match2, busy8, busy2;
  logic [7:0] cnt8;
  logic [1:0] cnt2;
  logic [1:0] st8, st2;

  seq_detect_param #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(8)) dut8 (
    .clk(clk), .reset(reset), .enable(enable), .din(din), .din_valid(din_valid),
    .cfg_load(cfg_load), .pattern_i(pattern_i), .len_i(len_i),
    .overlap_i(overlap_i), .cnt_clr(cnt_clr), .match(match8),
    .match_cnt(cnt8), .busy(busy8), .dbg_state(st8)
  );

  seq_detect_param #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .enable(enable), .din(din), .din_valid(din_valid),
    .cfg_load(cfg_load), .pattern_i(pattern_i), .len_i(len_i),
    .overlap_i(overlap_i), .cnt_clr(cnt_clr), .match(match2),
    .match_cnt(cnt2), .busy(busy2), .dbg_state(st2)
  );

  // ---------------- reference model ----------------
  int         checks = 0;
  int         errors = 0;
  logic       m_q[$];          // bits received since the last flush
  logic [7:0] m_pat    = 8'hFF;
  int         m_len    = 2;
  logic       m_ovl    = 1'b1;
  logic       m_active = 1'b0; // detector runs one cycle after enable is seen
  logic       m_match  = 1'b0;
  int         m_cnt8   = 0;
  int         m_cnt2   = 0;

  task automatic model_step();
    logic hit;
    hit = 1'b0;
    if (reset) begin
      m_q.delete();
      m_pat = 8'hFF; m_len = 2; m_ovl = 1'b1;
      m_active = 1'b0; m_cnt8 = 0; m_cnt2 = 0;
    end else begin
      if (cfg_load && !enable) begin
        m_pat = pattern_i;
        m_len = (len_i == 0 || int'(len_i) > PAT_W) ? PAT_W : int'(len_i);
        m_ovl = overlap_i;
      end
      if (m_active && enable && din_valid) begin
        m_q.push_back(din);
        if (m_q.size() > PAT_W) void'(m_q.pop_front());
        if (m_q.size() >= m_len) begin
          hit = 1'b1;
          for (int i = 0; i < m_len; i++)
            if (m_q[m_q.size()-1-i] !== m_pat[i]) hit = 1'b0;
        end
        if (hit && !m_ovl) m_q.delete();
      end
      if (!enable) m_q.delete();
      if (cnt_clr) begin
        m_cnt8 = 0; m_cnt2 = 0;
      end else if (hit) begin
        if (m_cnt8 < 255) m_cnt8++;
        if (m_cnt2 < 3) m_cnt2++;
      end
      m_active = enable;
    end
    m_match = hit;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("match8", {7'd0, match8}, {7'd0, m_match});
    chk("match2", {7'd0, match2}, {7'd0, m_match});
    chk("cnt8",   cnt8, 8'(m_cnt8));
    chk("cnt2",   {6'd0, cnt2}, 8'(m_cnt2));
    chk("busy8",  {7'd0, busy8}, {7'd0, m_active});
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic send(input logic b);
    din = b; din_valid = 1'b1;
    tick();
    din_valid = 1'b0; din = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ovl);
    enable = 1'b0; cfg_load = 1'b1;
    pattern_i = pat; len_i = len; overlap_i = ovl;
    tick();
    cfg_load = 1'b0;
  endtask

  task automatic start();
    enable = 1'b1;
    tick();
  endtask

  task automatic clear_cnt();
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    logic [6:0] s2;
    s2 = 7'b1011011;

    // Reset state
    do_reset();
    chk("rst_cnt", cnt8, 8'd0);
    chk("rst_busy", {7'd0, busy8}, 8'd0);

    // 1: legacy "11" detector
    start();
    send(1); send(1); send(1); send(0); send(1); send(1);
    tick();
    chk("t1_cnt", cnt8, 8'd3);

    // 2: pattern 1011, overlap
    load(8'h0B, 4'd4, 1'b1);
    clear_cnt();
    start();
    for (int i = 6; i >= 0; i--) send(s2[i]);
    tick();
    chk("t2_cnt", cnt8, 8'd2);

    // 3: same stream, non-overlap
    load(8'h0B, 4'd4, 1'b0);
    clear_cnt();
    start();
    for (int i = 6; i >= 0; i--) send(s2[i]);
    tick();
    chk("t3_cnt", cnt8, 8'd1);

    // 4: "11" with an invalid gap in between
    do_reset();
    start();
    send(1);
    tick(); tick(); tick();
    send(1);
    chk("t4_match", {7'd0, match8}, 8'd1);
    tick();
    chk("t4_cnt", cnt8, 8'd1);

    // 5: reset mid-pattern, then a fresh pattern
    load(8'h0B, 4'd4, 1'b1);
    start();
    send(1); send(0); send(1);
    do_reset();
    load(8'h0B, 4'd4, 1'b1);
    start();
    send(1);
    chk("t5_nomatch", {7'd0, match8}, 8'd0);
    send(1); send(0); send(1); send(1);
    chk("t5_match", {7'd0, match8}, 8'd1);

    // 6: counter saturation and clear priority
    load(8'h01, 4'd1, 1'b1);
    clear_cnt();
    start();
    for (int i = 0; i < 5; i++) send(1);
    chk("t6_sat2", {6'd0, cnt2}, 8'd3);
    chk("t6_cnt8", cnt8, 8'd5);
    cnt_clr = 1'b1; send(1); cnt_clr = 1'b0;
    chk("t6_clr2", {6'd0, cnt2}, 8'd0);

    // len clamp: len_i=0 means PAT_W
    load(8'hA5, 4'd0, 1'b1);
    start();
    for (int i = 7; i >= 0; i--) send(s2[i % 7] ^ 1'b0);
    enable = 1'b0; tick();

    // Randomized phase
    for (int n = 0; n < 1500; n++) begin
      reset     = ($urandom_range(0, 199) == 0);
      cfg_load  = ($urandom_range(0, 39) == 0);
      pattern_i = 8'($urandom);
      len_i     = 4'($urandom_range(0, 15));
      overlap_i = 1'($urandom);
      cnt_clr   = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 29) == 0) enable = ~enable;
      din_valid = ($urandom_range(0, 9) < 7);
      din       = ($urandom_range(0, 3) != 0);
      // bias toward short patterns so matches actually occur
      if (cfg_load && $urandom_range(0, 1) == 1) len_i = 4'($urandom_range(1, 3));
      tick();
    end
    reset = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0; din_valid = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule : tb_seq_detect_param

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
Parametrised serial pattern detector. Generalises the fixed two-bit "11" Mealy detector to a run-time programmable pattern of length 1..PAT_W. Adds an input-valid qualifier, an overlap/non-overlap mode, a registered match pulse and a saturating match counter. Sits on a serial bitstream path (UART/line decoder) and flags sync words.

Parameters:
PAT_W, 8, maximum pattern length in bits (>=2)
LEN_W, 4, width of length field; must hold PAT_W, i.e. ceil(log2(PAT_W+1))
CNT_W, 8, width of saturating match counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
enable  in  1  1 = detector running; 0 = idle, history flushed
din  in  1  serial data bit
din_valid  in  1  din is sampled only when 1
cfg_load  in  1  capture pattern_i/len_i/overlap_i; honoured only when enable=0
pattern_i  in  PAT_W  pattern; pattern_i[len-1] is the first bit received, pattern_i[0] the last
len_i  in  LEN_W  pattern length; 0 or >PAT_W clamps to PAT_W at load
overlap_i  in  1  1 = overlapping matches allowed; 0 = history cleared after each match
cnt_clr  in  1  synchronous clear of match_cnt
match  out  1  one-cycle pulse, registered
match_cnt  out  CNT_W  saturating count of matches
busy  out  1  1 when state != IDLE

Behaviour:
- Reset: state=IDLE, hist=0, fill_cnt=0, match=0, match_cnt=0. Config registers reset to pattern=all ones, len=2, overlap=1, which reproduces the legacy "11" detector.
- Config: on cfg_load=1 with enable=0, capture pattern, clamped len and overlap. cfg_load with enable=1 is ignored.
- History: hist[PAT_W-1:0] shifts left on each valid bit, new bit into LSB.
- The window is {hist[len-2:0], din}, i.e. the low len bits of the post-shift history.
- fill_cnt counts valid bits since the last flush and saturates at len.
- FSM states:
  - IDLE: enable=0; hist and fill_cnt held at 0; no match. Goes to FILL when enable=1.
  - FILL: fill_cnt < len-1. Each valid bit increments fill_cnt. Moves to RUN when a valid bit brings fill_cnt to len-1 and no match occurs on it. A match is possible on the bit that completes the window (e.g. len=1).
  - RUN: window full. Every valid bit is compared.
  - Any state goes to IDLE in the cycle after enable falls, flushing history.
- Match condition: state in FILL or RUN, din_valid=1, fill_cnt >= len-1, and window == pattern_i[len-1:0].
  - match is registered: high exactly one cycle, in the cycle after the sampling edge of the last pattern bit. Latency is 1 clk.
  - din_valid=0 leaves hist, fill_cnt, state and match_cnt unchanged; match=0.
- Overlap=1: history keeps shifting after a match, so the tail of one match can start the next.
- Overlap=0: on a match, fill_cnt clears to 0 and state goes to FILL. The next match needs len fresh valid bits.
- match_cnt:
  - Increments on each match, saturating at 2^CNT_W-1.
  - cnt_clr has priority: cnt_clr together with a match gives 0.
  - cnt_clr works in any state, including IDLE.
- Reset mid-stream: all state is lost and the partial window is discarded. No match is emitted on the cycle reset is asserted.
- enable dropping mid-stream: no match is emitted for bits sampled while enable=0. match_cnt is retained.
- len=1: every valid bit equal to pattern_i[0] matches. Overlap has no effect.

Decomposition:
- Package seq_detect_pkg holds:
  - state encoding constants IDLE=2'd0, FILL=2'd1, RUN=2'd2;
  - default-config constants (pattern all ones, len 2, overlap 1).
- One natural sub-module: sat_counter (parameter W; inputs inc and clr, clr wins; output cnt). Reusable elsewhere.
- Window compare (masked equality on the low len bits) stays inline in combinational logic.

Test Plan:
1. Default config after reset, enable=1, valid bits 1,1,1,0,1,1: match pulses after bits 2, 3 and 6; match_cnt=3.
2. Load pattern 4'b1011 (PAT_W=8, value 8'h0B), len=4, overlap=1, stream 1,0,1,1,0,1,1: matches after bits 4 and 7; match_cnt=2.
3. Same stream, overlap=0: match only after bit 4; match_cnt=1.
4. Pattern 11, stream 1, gap (din_valid=0 for 3 cycles, din=0), 1: one match, one cycle after the second valid bit. No match during the gap.
5. Assert reset after the first 3 bits of 1011, then send 1: no match. A fresh 1,0,1,1 matches.
6. CNT_W=2, 5 matches gives match_cnt=3 (saturated). cnt_clr coincident with the 6th match gives match_cnt=0.
